ll_deq_scheduler: RTL
=====================

LL_DEQ_SCHEDULER -- requirements
Module: ll_deq_scheduler

Interface
REQ-001 Parameter NUM_QUEUES, default 4: number of linked-list queues served.
REQ-002 Parameter LL_DEPTH, default 64: total entries shared by all queues.
REQ-003 Parameter DATA_WIDTH, default 6: payload width.
REQ-004 Parameter READ_DELAY, default 3: linked-list dequeue read latency in cycles.
REQ-005 Parameter OUT_DEPTH, default 4: output skid FIFO depth.
REQ-006 Port clk  input  1: single clock for the block.
REQ-007 Port reset  input  1: asynchronous, active-low reset (asserted when 0).
REQ-008 Port init_done  input  1: linked list finished free-list init.
REQ-009 Port in_vld / in_rdy  input / output  1 / 1: upstream enqueue handshake.
REQ-010 Port in_id  input  $clog2(NUM_QUEUES): target queue.
REQ-011 Port in_data  input  DATA_WIDTH: enqueue payload.
REQ-012 Port enq_vld_out / enq_id_out / enq_data_out  output  1 / $clog2(NUM_QUEUES) / DATA_WIDTH: drive linked-list enqueue.
REQ-013 Port deq_vld_out / deq_id_out  output  1 / $clog2(NUM_QUEUES): drive linked-list dequeue.
REQ-014 Port deq_data_in  input  DATA_WIDTH: linked-list dequeue data.
REQ-015 Port queue_en  input  NUM_QUEUES: per-queue dequeue enable mask.
REQ-016 Port out_vld / out_rdy  output / input  1 / 1: downstream stream handshake.
REQ-017 Port out_id / out_data  output  $clog2(NUM_QUEUES) / DATA_WIDTH: source queue and payload.
REQ-018 Port queue_cnt  output  NUM_QUEUES x $clog2(LL_DEPTH+1): per-queue occupancy.

Function
REQ-019 in_rdy SHALL be 1 only when init_done=1 and global count < LL_DEPTH; enq_*_out SHALL be combinational pass-through of in_* with enq_vld_out = in_vld & in_rdy.
REQ-020 Per-queue and global counts SHALL be registered: +1 on accepted enqueue, -1 on issued dequeue; enqueue and dequeue on same queue in same cycle SHALL leave that count unchanged.
REQ-021 A queue SHALL be eligible when registered count > 0, queue_en bit = 1, and init_done = 1; an enqueue in the current cycle SHALL NOT make an empty queue eligible that cycle.
REQ-022 At most one dequeue per cycle SHALL issue, only when at least one queue is eligible and (FIFO occupancy + in-flight count) < OUT_DEPTH.
REQ-023 Grant SHALL be round-robin: search starts at last granted id + 1, wrapping NUM_QUEUES-1 -> 0; pointer updates only on issue.
REQ-024 A READ_DELAY-stage valid/id shift register SHALL track in-flight reads; deq_data_in SHALL be written into the FIFO, tagged with the issued id, on the READ_DELAY-th rising edge after the edge sampling deq_vld_out=1.
REQ-025 In-flight count SHALL equal the number of set valid bits in the shift register (0..READ_DELAY).
REQ-026 FIFO SHALL be first-word-fall-through: out_vld = non-empty; pop on out_vld & out_rdy; simultaneous push and pop SHALL hold occupancy; credit rule (REQ-022) guarantees no overflow.
REQ-027 Dequeue order per queue SHALL be preserved at the output; inter-queue order follows issue order.
REQ-028 init_done falling to 0 SHALL stop new enqueues and dequeues; in-flight reads SHALL still complete into the FIFO.

Reset
REQ-029 While reset=0: all counts, round-robin pointer (0), shift register, FIFO pointers cleared; deq_vld_out=0, out_vld=0, in_rdy=0.
REQ-030 Reset mid-operation SHALL discard in-flight reads and FIFO contents; no output valid until new data arrives after reset release.

Structure
REQ-031 Shared package ll_pkg SHALL hold default parameter constants, derived widths (QID_W, CNT_W), and a typedef struct {qid, data} for tagged FIFO entries.
REQ-032 Round-robin arbitration SHALL be a separate sub-module rr_arbiter (request vector, enable, grant id, grant valid).

Verification (NUM_QUEUES=4, LL_DEPTH=64, DATA_WIDTH=6, READ_DELAY=3, OUT_DEPTH=4)
REQ-033 Enqueue 1,2 to queue 0, out_rdy=1 -> deq_vld_out on consecutive cycles, out_data 1 then 2, out_id 0, first output 3 cycles after first issue.
REQ-034 Queues 0..3 each hold 2 items, all enabled -> issue ids 0,1,2,3,0,1,2,3.
REQ-035 out_rdy=0, queue 1 holds 10 items -> exactly 4 dequeues issued then stall; out_rdy=1 resumes, all 10 delivered in order.
REQ-036 Fill 64 items -> in_rdy=0 at count 64; one dequeue -> in_rdy=1 next cycle.
REQ-037 queue_en=4'b1101 with all queues non-empty -> queue 1 never granted; queue_cnt[1] unchanged.
REQ-038 Assert reset with 3 reads in flight -> out_vld=0, all queue_cnt=0 after release, no stale output.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared constants and types for the linked-list dequeue scheduler.
package ll_pkg;

    localparam int NUM_QUEUES_DEF = 4;
    localparam int LL_DEPTH_DEF   = 64;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int READ_DELAY_DEF = 3;
    localparam int OUT_DEPTH_DEF  = 4;

    localparam int QID_W = $clog2(NUM_QUEUES_DEF);
    localparam int CNT_W = $clog2(LL_DEPTH_DEF + 1);

    // Output FIFO entry: payload tagged with its source queue.
    typedef struct packed {
        logic [QID_W-1:0]          qid;
        logic [DATA_WIDTH_DEF-1:0] data;
    } ll_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted id.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [W-1:0] gnt_id,
    output logic         gnt_vld
);

    logic [W-1:0] ptr;
    logic         found;
    int unsigned  idx;

    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[W'(idx)]) begin
                found  = 1'b1;
                gnt_id = W'(idx);
            end
        end
        gnt_vld = found & en;
    end

    // ptr holds the next search start, i.e. last granted id + 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/ll_deq_scheduler.sv
// Enqueue gate, per-queue occupancy, round-robin dequeue issue and a
// credit-protected output skid FIFO fed by the linked-list read pipeline.
module ll_deq_scheduler
    import ll_pkg::*;
#(
    parameter int NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int LL_DEPTH   = LL_DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int READ_DELAY = READ_DELAY_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
    localparam int QW = $clog2(NUM_QUEUES),
    localparam int CW = $clog2(LL_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init_done,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic [QW-1:0]                  in_id,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           enq_vld_out,
    output logic [QW-1:0]                  enq_id_out,
    output logic [DATA_WIDTH-1:0]          enq_data_out,
    output logic                           deq_vld_out,
    output logic [QW-1:0]                  deq_id_out,
    input  logic [DATA_WIDTH-1:0]          deq_data_in,
    input  logic [NUM_QUEUES-1:0]          queue_en,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [QW-1:0]                  out_id,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [NUM_QUEUES-1:0][CW-1:0]  queue_cnt
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FW = $clog2(OUT_DEPTH + 1);
    localparam int IW = $clog2(READ_DELAY + 1);
    localparam logic [CW-1:0] LL_FULL = CW'(LL_DEPTH);

    typedef struct packed {
        logic [QW-1:0]         qid;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [CW-1:0]         total_cnt;
    logic [NUM_QUEUES-1:0] eligible, cnt_inc, cnt_dec;
    logic                  credit_ok, issue_en;
    logic [IW-1:0]         inflight;
    logic [FW-1:0]         fifo_cnt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop;
    entry_t                mem [OUT_DEPTH];

    logic [READ_DELAY-1:0]         sr_vld;
    logic [READ_DELAY-1:0][QW-1:0] sr_id;
    logic [READ_DELAY:0]           vld_chain;
    logic [READ_DELAY:0][QW-1:0]   id_chain;

    assign in_rdy       = reset & init_done & (total_cnt < LL_FULL);
    assign enq_vld_out  = in_vld & in_rdy;
    assign enq_id_out   = in_id;
    assign enq_data_out = in_data;

    always_comb begin
        eligible = '0;
        cnt_inc  = '0;
        cnt_dec  = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            eligible[q] = init_done & queue_en[q] & (queue_cnt[q] != '0);
            cnt_inc[q]  = enq_vld_out & (in_id == QW'(q));
            cnt_dec[q]  = deq_vld_out & (deq_id_out == QW'(q));
        end
    end

    // Reads already in flight hold FIFO slots so a stalled output never overflows.
    assign inflight  = IW'($countones(sr_vld));
    assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < 32'(OUT_DEPTH);
    assign issue_en  = init_done & credit_ok;

    rr_arbiter #(.N(NUM_QUEUES), .W(QW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .en      (issue_en),
        .gnt_id  (deq_id_out),
        .gnt_vld (deq_vld_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            queue_cnt <= '0;
            total_cnt <= '0;
        end else begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                if (cnt_inc[q] && !cnt_dec[q])      queue_cnt[q] <= queue_cnt[q] + 1'b1;
                else if (!cnt_inc[q] && cnt_dec[q]) queue_cnt[q] <= queue_cnt[q] - 1'b1;
            end
            if (enq_vld_out && !deq_vld_out)      total_cnt <= total_cnt + 1'b1;
            else if (!enq_vld_out && deq_vld_out) total_cnt <= total_cnt - 1'b1;
        end
    end

    // Prepending the issue signal lets the same slice work for READ_DELAY == 1.
    assign vld_chain = {sr_vld, deq_vld_out};
    assign id_chain  = {sr_id, deq_id_out};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_vld <= '0;
            sr_id  <= '0;
        end else begin
            sr_vld <= vld_chain[READ_DELAY-1:0];
            sr_id  <= id_chain[READ_DELAY-1:0];
        end
    end

    assign push = sr_vld[READ_DELAY-1];
    assign pop  = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{qid: sr_id[READ_DELAY-1], data: deq_data_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    assign out_vld  = (fifo_cnt != '0);
    assign out_id   = mem[rd_ptr].qid;
    assign out_data = mem[rd_ptr].data;

endmodule
